// File: rtl/mem_fill_responder.sv
// Memory-side responder for cache line fills: one request per cycle, reads return
// after a fixed LATENCY through a shift pipe, writes update the array in place.
module mem_fill_responder #(
    parameter int LATENCY  = 4,
    parameter int AW_WORDS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_id,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] data_addr,
    output logic        data_id,
    output logic [3:0]  in_flight,
    output logic        busy
);

    localparam int DEPTH = 1 << AW_WORDS;

    // Handshake: a request is taken on every edge where req_valid=1 (there is no
    // ready, the responder never stalls); data_valid=1 marks a response for one cycle.
    logic [15:0]         mem [DEPTH];
    logic [AW_WORDS-1:0] word_idx;
    logic                rd_issue;
    logic                wr_issue;
    logic                rd_retire;
    logic                unused_addr_bit0;

    logic [LATENCY-1:0]  pipe_valid;
    logic [14:0]         pipe_addr [LATENCY];
    logic                pipe_id   [LATENCY];
    logic [15:0]         pipe_data [LATENCY];

    assign word_idx         = req_addr[AW_WORDS:1];
    assign rd_issue         = req_valid & ~req_wr;
    assign wr_issue         = req_valid & req_wr;
    assign rd_retire        = pipe_valid[LATENCY-1];
    assign unused_addr_bit0 = req_addr[0];

    // The array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_issue) begin
            mem[word_idx] <= req_wdata;
        end
    end

    // Payload only advances behind a valid slot, so the last stage (and hence the
    // outputs) holds the most recent response while data_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_addr[i] <= '0;
                pipe_id[i]   <= 1'b0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_issue;
            if (rd_issue) begin
                pipe_addr[0] <= req_addr[15:1];
                pipe_id[0]   <= req_id;
                pipe_data[0] <= mem[word_idx];
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_addr[i] <= pipe_addr[i-1];
                    pipe_id[i]   <= pipe_id[i-1];
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 4'd0;
        end else if (rd_issue && !rd_retire) begin
            in_flight <= in_flight + 4'd1;
        end else if (!rd_issue && rd_retire) begin
            in_flight <= in_flight - 4'd1;
        end
    end

    assign busy       = (in_flight != 4'd0);
    assign data_valid = pipe_valid[LATENCY-1];
    assign data_out   = pipe_data[LATENCY-1];
    assign data_addr  = {pipe_addr[LATENCY-1], 1'b0};
    assign data_id    = pipe_id[LATENCY-1];

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: three instances (LATENCY 1, 4, 8) share one request
// stream and are compared every cycle against a queue-based reference model.
module tb_mem_fill_responder;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic [15:0] a;
        logic        id;
        logic [3:0]  n;
        logic        b;
    } obs_t;

    typedef struct {
        int          issue;
        logic [15:0] addr;
        logic        id;
        logic [15:0] data;
    } rd_t;

    typedef struct {
        logic        v;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        id;
    } op_t;

    // ---------------- clock / reset / DUTs ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_id = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;

    logic        dv    [3];
    logic [15:0] dout  [3];
    logic [15:0] daddr [3];
    logic        did   [3];
    logic [3:0]  nfl   [3];
    logic        bsy   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_fill_responder #(
            .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 4 : 8)),
            .AW_WORDS (15)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid),
            .req_wr     (req_wr),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_id     (req_id),
            .data_out   (dout[g]),
            .data_valid (dv[g]),
            .data_addr  (daddr[g]),
            .data_id    (did[g]),
            .in_flight  (nfl[g]),
            .busy       (bsy[g])
        );
    end

    // ---------------- reference model ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    rd_t         exp_q [$];
    int          head [3];
    obs_t        last [3];
    logic [15:0] shadow [int];

    function automatic int lat_of(input int l);
        return (l == 0) ? 1 : ((l == 1) ? 4 : 8);
    endfunction

    function automatic obs_t observe(input int l);
        obs_t o;
        o.v = dv[l]; o.d = dout[l]; o.a = daddr[l];
        o.id = did[l]; o.n = nfl[l]; o.b = bsy[l];
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("v=%b d=%h a=%h id=%b n=%0d busy=%b", o.v, o.d, o.a, o.id, o.n, o.b);
    endfunction

    // Reads outstanding for lane l are exp_q[head[l]..]; each returns exactly
    // lat cycles after its issue cycle, and in_flight counts those not yet gone.
    function automatic obs_t model_step(input int l);
        obs_t e;
        int   n;
        n = exp_q.size() - head[l];
        e = last[l];
        e.v = 1'b0;
        if (n > 0 && exp_q[head[l]].issue + lat_of(l) == cyc) begin
            e.v  = 1'b1;
            e.d  = exp_q[head[l]].data;
            e.a  = exp_q[head[l]].addr;
            e.id = exp_q[head[l]].id;
            head[l]++;
        end
        e.n = 4'(n);
        e.b = (n != 0);
        last[l] = e;
        return e;
    endfunction

    function automatic void model_reset();
        for (int l = 0; l < 3; l++) begin
            head[l] = exp_q.size();
            last[l] = '0;
        end
    endfunction

    function automatic op_t mk_rd(input logic [15:0] addr, input logic id);
        op_t o;
        o.v = 1'b1; o.wr = 1'b0; o.addr = addr; o.wdata = 16'(($urandom)); o.id = id;
        return o;
    endfunction

    function automatic op_t mk_wr(input logic [15:0] addr, input logic [15:0] data);
        op_t o;
        o.v = 1'b1; o.wr = 1'b1; o.addr = addr; o.wdata = data; o.id = 1'($urandom);
        return o;
    endfunction

    function automatic op_t mk_idle();
        op_t o;
        o.v = 1'b0; o.wr = 1'($urandom); o.addr = 16'($urandom);
        o.wdata = 16'($urandom); o.id = 1'($urandom);
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input op_t op);
        int  k;
        rd_t r;
        @(negedge clk);
        req_valid = op.v; req_wr = op.wr; req_addr = op.addr;
        req_wdata = op.wdata; req_id = op.id;
        k = int'(op.addr[15:1]);
        if (op.v && !op.wr) begin
            r.issue = cyc;
            r.addr  = {op.addr[15:1], 1'b0};
            r.id    = op.id;
            r.data  = shadow.exists(k) ? shadow[k] : 16'h0000;
            exp_q.push_back(r);
        end
        if (op.v && op.wr) shadow[k] = op.wdata;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        for (int l = 0; l < 3; l++) begin
            obs_t e, o;
            e = model_step(l);
            o = observe(l);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset lat=%0d got %s exp %s", lat_of(l), fmt(o), fmt(e));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        op_t ops [$];
        ops.push_back(mk_wr(16'h0040, 16'hBEEF));
        ops.push_back(mk_idle());
        ops.push_back(mk_rd(16'h0040, 1'b0));
        for (int i = 0; i < 9; i++) ops.push_back(mk_idle());
        ops.push_back(mk_rd(16'h0041, 1'b1));
        for (int i = 0; i < 9; i++) ops.push_back(mk_idle());
        foreach (ops[i]) begin
            drive(ops[i]);
            for (int l = 0; l < 3; l++) begin
                obs_t e, o;
                e = model_step(l);
                o = observe(l);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_read lat=%0d cyc=%0d got %s exp %s", lat_of(l), cyc, fmt(o), fmt(e));
                end
            end
        end
    endtask

    task automatic test_line_fill();
        op_t ops [$];
        int  peak [3];
        for (int i = 0; i < 8; i++) ops.push_back(mk_wr(16'h1230 + 16'(2 * i), 16'($urandom)));
        for (int i = 0; i < 8; i++) ops.push_back(mk_rd(16'h1230 + 16'(2 * i), 1'b1));
        for (int i = 0; i < 10; i++) ops.push_back(mk_idle());
        for (int l = 0; l < 3; l++) peak[l] = 0;
        foreach (ops[i]) begin
            drive(ops[i]);
            for (int l = 0; l < 3; l++) begin
                obs_t e, o;
                e = model_step(l);
                o = observe(l);
                if (int'(o.n) > peak[l]) peak[l] = int'(o.n);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL line_fill lat=%0d cyc=%0d got %s exp %s", lat_of(l), cyc, fmt(o), fmt(e));
                end
            end
        end
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (peak[l] != lat_of(l)) begin
                errors++;
                $display("FAIL line_fill_peak lat=%0d got %0d exp %0d", lat_of(l), peak[l], lat_of(l));
            end
        end
    endtask

    task automatic test_write_order();
        op_t ops [$];
        ops.push_back(mk_wr(16'h0100, 16'h1234));
        ops.push_back(mk_rd(16'h0100, 1'b0));
        ops.push_back(mk_idle());
        ops.push_back(mk_rd(16'h0100, 1'b1));
        ops.push_back(mk_wr(16'h0100, 16'h5678));
        ops.push_back(mk_rd(16'h0101, 1'b0));
        for (int i = 0; i < 10; i++) ops.push_back(mk_idle());
        foreach (ops[i]) begin
            drive(ops[i]);
            for (int l = 0; l < 3; l++) begin
                obs_t e, o;
                e = model_step(l);
                o = observe(l);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL write_order lat=%0d cyc=%0d got %s exp %s", lat_of(l), cyc, fmt(o), fmt(e));
                end
            end
        end
    endtask

    task automatic test_interleave();
        op_t ops [$];
        ops.push_back(mk_wr(16'h2000, 16'($urandom)));
        ops.push_back(mk_wr(16'h2002, 16'($urandom)));
        ops.push_back(mk_wr(16'h3000, 16'($urandom)));
        ops.push_back(mk_wr(16'h3002, 16'($urandom)));
        ops.push_back(mk_rd(16'h2000, 1'b0));
        ops.push_back(mk_rd(16'h3000, 1'b1));
        ops.push_back(mk_rd(16'h2002, 1'b0));
        ops.push_back(mk_rd(16'h3002, 1'b1));
        for (int i = 0; i < 10; i++) ops.push_back(mk_idle());
        foreach (ops[i]) begin
            drive(ops[i]);
            for (int l = 0; l < 3; l++) begin
                obs_t e, o;
                e = model_step(l);
                o = observe(l);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL interleave lat=%0d cyc=%0d got %s exp %s", lat_of(l), cyc, fmt(o), fmt(e));
                end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        op_t ops [$];
        for (int i = 0; i < 8; i++) drive(mk_wr(16'h1230 + 16'(2 * i), 16'($urandom)));
        for (int l = 0; l < 3; l++) void'(model_step(l));
        // Reads 0 and 1 of the fill, then reset lands in cycle 2.
        for (int i = 0; i < 2; i++) ops.push_back(mk_rd(16'h1230 + 16'(2 * i), 1'b1));
        ops.push_back(mk_idle());
        ops.push_back(mk_idle());
        foreach (ops[i]) begin
            drive(ops[i]);
            for (int l = 0; l < 3; l++) begin
                obs_t e, o;
                e = model_step(l);
                o = observe(l);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_mid_fill lat=%0d cyc=%0d step=%0d got %s exp %s", lat_of(l), cyc, i, fmt(o), fmt(e));
                end
            end
            if (i == 1) begin
                @(negedge clk);
                req_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                model_reset();
                for (int l = 0; l < 3; l++) begin
                    obs_t e, o;
                    e = model_step(l);
                    o = observe(l);
                    checks++;
                    if (o !== e) begin
                        errors++;
                        $display("FAIL reset_mid_fill_async lat=%0d got %s exp %s", lat_of(l), fmt(o), fmt(e));
                    end
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        ops.delete();
        ops.push_back(mk_rd(16'h1234, 1'b0));
        for (int i = 0; i < 10; i++) ops.push_back(mk_idle());
        foreach (ops[i]) begin
            drive(ops[i]);
            for (int l = 0; l < 3; l++) begin
                obs_t e, o;
                e = model_step(l);
                o = observe(l);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL post_reset_read lat=%0d cyc=%0d got %s exp %s", lat_of(l), cyc, fmt(o), fmt(e));
                end
            end
        end
    endtask

    task automatic test_random_traffic();
        logic [15:0] pool [16];
        op_t         op;
        for (int i = 0; i < 16; i++) begin
            pool[i] = {4'($urandom_range(0, 15)), 11'($urandom), 1'b0};
            drive(mk_wr(pool[i], 16'($urandom)));
            for (int l = 0; l < 3; l++) void'(model_step(l));
        end
        for (int c = 0; c < 310; c++) begin
            if (c >= 300 || $urandom_range(0, 9) < 3) begin
                op = mk_idle();
            end else if ($urandom_range(0, 9) < 3) begin
                op = mk_wr(pool[$urandom_range(0, 15)] | 16'($urandom_range(0, 1)), 16'($urandom));
            end else begin
                op = mk_rd(pool[$urandom_range(0, 15)] | 16'($urandom_range(0, 1)), 1'($urandom));
            end
            drive(op);
            for (int l = 0; l < 3; l++) begin
                obs_t e, o;
                e = model_step(l);
                o = observe(l);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random lat=%0d cyc=%0d got %s exp %s", lat_of(l), cyc, fmt(o), fmt(e));
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_line_fill();
        test_write_order();
        test_interleave();
        test_reset_mid_fill();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
